uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset: clk_in is the only clock and rst_in is sampled only on the rising edge of clk_in.
REQ-002 Parameter CYCLES_PER_BIT SHALL default to 868 and sets the clk_in cycles per serial bit (100 MHz / 115200 baud); legal range is >= 2.
REQ-003 Parameter PARITY_EN SHALL default to 0; 1 inserts an even-parity bit after the data bits.
REQ-004 Parameter STOP_BITS SHALL default to 1; legal values are 1 or 2.
REQ-005 clk_in  input  1  system clock.
REQ-006 rst_in  input  1  synchronous active-high reset.
REQ-007 data_in  input  8  byte to transmit, sampled only on handshake.
REQ-008 valid_in  input  1  byte on data_in is valid.
REQ-009 ready_out  output  1  block can accept a byte this cycle.
REQ-010 tx_out  output  1  serial line, idle high, registered.
REQ-011 busy_out  output  1  a frame is in progress.
REQ-012 done_out  output  1  one-cycle pulse after a frame completes.

Function
REQ-013 A handshake SHALL occur in any cycle with valid_in=1, ready_out=1 and rst_in=0; data_in is latched internally in that cycle.
REQ-014 ready_out SHALL be 1 only in the IDLE state and SHALL drop to 0 in the cycle after a handshake.
REQ-015 The state machine SHALL be IDLE -> START -> DATA -> PARITY (only if PARITY_EN=1) -> STOP -> IDLE.
REQ-016 On handshake in cycle T, tx_out SHALL go low (start bit) at T+1 and remain low for exactly CYCLES_PER_BIT cycles.
REQ-017 DATA SHALL shift out 8 bits LSB first, each held exactly CYCLES_PER_BIT cycles.
REQ-018 The parity bit SHALL be the XOR of the 8 latched data bits (even parity) and SHALL last CYCLES_PER_BIT cycles.
REQ-019 STOP SHALL drive tx_out=1 for STOP_BITS*CYCLES_PER_BIT cycles.
REQ-020 Frame length SHALL be (9+PARITY_EN+STOP_BITS)*CYCLES_PER_BIT cycles, with no cycle added or dropped at any bit boundary.
REQ-021 In the first cycle after the last stop-bit cycle, the block SHALL be in IDLE with ready_out=1, done_out=1 for that one cycle and busy_out=0.
REQ-022 Back-to-back: a handshake in that IDLE cycle SHALL start the next start bit on the following cycle, giving exactly one idle-high cycle between frames.
REQ-023 busy_out SHALL be 1 from the cycle after a handshake through the last stop-bit cycle inclusive.
REQ-024 Changes on data_in or valid_in during a frame SHALL have no effect on the frame in progress.
REQ-025 The bit-period counter SHALL be $clog2(CYCLES_PER_BIT)+1 bits wide and SHALL count 0..CYCLES_PER_BIT-1, wrapping to 0 at each bit boundary.
REQ-026 The bit index counter SHALL count 0..7 within DATA and SHALL reset to 0 on entry to DATA.
REQ-027 tx_out SHALL be glitch-free, driven directly from a flop.

Reset
REQ-028 While rst_in=1, the outputs SHALL be tx_out=1, ready_out=1, busy_out=0 and done_out=0; the state SHALL be IDLE and all counters 0.
REQ-029 rst_in asserted mid-frame SHALL abort the frame, force tx_out=1 on the next edge, and produce no done_out pulse.
REQ-030 valid_in SHALL be ignored in any cycle where rst_in=1.
REQ-031 After rst_in deasserts, a handshake SHALL be accepted in the first cycle.

Verification
REQ-032 With CYCLES_PER_BIT=4, PARITY_EN=0, STOP_BITS=1, send 0xA5 at cycle T -> tx_out bits 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles over T+1..T+40; done_out=1 and ready_out=1 at T+41.
REQ-033 Same parameters with PARITY_EN=1, send 0x07 -> parity bit=1, frame 44 cycles, done_out at T+45.
REQ-034 Hold valid_in=1 with 0x00 then 0xFF -> second start bit at T+42, exactly one idle cycle with tx_out=1 between frames, two done_out pulses total.
REQ-035 Assert rst_in for 1 cycle at T+10 of a frame -> tx_out=1 at T+11, ready_out=1, no done_out pulse, and a new handshake is accepted at T+11.
REQ-036 Toggle data_in every cycle during a 0x3C frame -> serialized bits match 0x3C exactly.
REQ-037 With STOP_BITS=2 and CYCLES_PER_BIT=868 -> frame is 9548 cycles and tx_out is high for the final 1736 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter, optional even parity, 1 or 2 stop bits
module uart_tx #(
  parameter int CYCLES_PER_BIT = 868,
  parameter int PARITY_EN      = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy_out,
  output logic       done_out
);

  localparam int CW = $clog2(CYCLES_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic          stop_cnt;
  logic [7:0]    shreg;
  logic          parity;
  logic          bit_end;

  assign bit_end = (bit_cnt == LAST_CNT);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      parity    <= 1'b0;
      tx_out    <= 1'b1;
      ready_out <= 1'b1;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            shreg     <= data_in;
            parity    <= ^data_in;
            bit_cnt   <= '0;
            state     <= START;
            tx_out    <= 1'b0;
            ready_out <= 1'b0;
            busy_out  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx_out  <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (PARITY_EN != 0) begin
                state  <= PARITY;
                tx_out <= parity;
              end else begin
                state    <= STOP;
                stop_cnt <= 1'b0;
                tx_out   <= 1'b1;
              end
            end else begin
              // next bit comes from shreg[1] because the shift lands this same edge
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_out  <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            state    <= STOP;
            tx_out   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state     <= IDLE;
              ready_out <= 1'b1;
              busy_out  <= 1'b0;
              done_out  <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          tx_out    <= 1'b1;
          ready_out <= 1'b1;
          busy_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized bench for uart_tx against a cycle-indexed frame model
module tb_uart_tx;

  localparam int CPB0 = 4;
  localparam int PAR0 = 0;
  localparam int STP0 = 1;
  localparam int CPB1 = 3;
  localparam int PAR1 = 1;
  localparam int STP1 = 2;
  localparam int NCYC = 4000;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready0, tx0, busy0, done0;
  logic       ready1, tx1, busy1, done1;

  always #5 clk_in = ~clk_in;

  uart_tx #(.CYCLES_PER_BIT(CPB0), .PARITY_EN(PAR0), .STOP_BITS(STP0)) dut0 (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready0),
    .tx_out   (tx0),
    .busy_out (busy0),
    .done_out (done0)
  );

  uart_tx #(.CYCLES_PER_BIT(CPB1), .PARITY_EN(PAR1), .STOP_BITS(STP1)) dut1 (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready1),
    .tx_out   (tx1),
    .busy_out (busy1),
    .done_out (done1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
  endtask

  // Model: a frame is a list of bits; cycle k of the frame shows bit k/CPB.
  bit         m_busy[2];
  bit         m_done[2];
  int         m_k[2];
  logic [7:0] m_byte[2];

  function automatic int cpb_of(input int d);
    return (d == 0) ? CPB0 : CPB1;
  endfunction

  function automatic int frame_len(input int d);
    if (d == 0) return (9 + PAR0 + STP0) * CPB0;
    return (9 + PAR1 + STP1) * CPB1;
  endfunction

  function automatic logic exp_tx(input int d);
    int b;
    int par;
    if (!m_busy[d]) return 1'b1;
    par = (d == 0) ? PAR0 : PAR1;
    b = m_k[d] / cpb_of(d);
    if (b == 0) return 1'b0;
    if (b <= 8) return m_byte[d][b-1];
    if (b == 9 && par != 0) return ^m_byte[d];
    return 1'b1;
  endfunction

  task automatic model_step(input int d, input logic rst, input logic vld, input logic [7:0] dat);
    if (rst) begin
      m_busy[d] = 1'b0;
      m_done[d] = 1'b0;
    end else begin
      m_done[d] = 1'b0;
      if (!m_busy[d]) begin
        if (vld) begin
          m_busy[d] = 1'b1;
          m_k[d]    = 0;
          m_byte[d] = dat;
        end
      end else begin
        m_k[d]++;
        if (m_k[d] == frame_len(d)) begin
          m_busy[d] = 1'b0;
          m_done[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_dut(input int d, input logic tx, input logic rdy, input logic bsy, input logic dn);
    string p;
    p = (d == 0) ? "d0" : "d1";
    check({p, "_tx"},    {31'd0, tx},  {31'd0, exp_tx(d)});
    check({p, "_ready"}, {31'd0, rdy}, {31'd0, ~m_busy[d]});
    check({p, "_busy"},  {31'd0, bsy}, {31'd0, m_busy[d]});
    check({p, "_done"},  {31'd0, dn},  {31'd0, m_done[d]});
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_done[d] = 1'b0;
      m_k[d]    = 0;
      m_byte[d] = 8'h00;
    end
    rst_in   = 1'b1;
    valid_in = 1'b1;
    data_in  = 8'h5A;
    repeat (3) @(posedge clk_in);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk_in);
      check_dut(0, tx0, ready0, busy0, done0);
      check_dut(1, tx1, ready1, busy1, done1);
      rst_in   = ($urandom_range(0, 249) == 0);
      data_in  = 8'($urandom);
      valid_in = (c % 600 < 300) ? 1'b1 : ($urandom_range(0, 9) < 4);
      @(posedge clk_in);
      model_step(0, rst_in, valid_in, data_in);
      model_step(1, rst_in, valid_in, data_in);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
